// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline hazard/forwarding controller
//   FWD_RF/FWD_MEM/FWD_WB : ALU operand source selects
//   stage_info_t          : per-stage shadow of operand and destination info
//   hit / src_hit / fwd_sel : hazard match and forwarding priority helpers
package pipe_pkg;

    // Register fields are widened to AW_MAX so one struct serves any REG_AW up to it.
    localparam int AW_MAX = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef logic [AW_MAX-1:0] reg_t;

    typedef struct packed {
        logic valid;
        reg_t rs;
        reg_t rt;
        logic use_rs;
        logic use_rt;
        reg_t dst;
        logic regwr;
        logic load;
    } stage_info_t;

    // Stage x produces source s; register 0 never matches.
    function automatic logic hit(input stage_info_t x, input reg_t s, input logic use_s);
        return x.valid && x.regwr && x.dst == s && s != '0 && use_s;
    endfunction

    function automatic logic src_hit(input stage_info_t x, input stage_info_t id);
        return hit(x, id.rs, id.use_rs) || hit(x, id.rt, id.use_rt);
    endfunction

    // MEM is the younger producer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input stage_info_t mem, input stage_info_t wb,
                                           input reg_t s, input logic use_s);
        return hit(mem, s, use_s) ? FWD_MEM : hit(wb, s, use_s) ? FWD_WB : FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-side inputs and pipeline control outputs of the hazard controller
//   master : datapath/controller side, drives run and ID decode info, receives controls
//   slave  : hazard controller side
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              run;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_regwr;
    logic              id_load;
    logic              id_jump;
    logic              ex_br_taken;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output run, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwr, id_load, id_jump, ex_br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, stall, stall_cnt, flush_cnt
    );

    modport slave (
        input  run, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwr, id_load, id_jump, ex_br_taken,
        output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b, stall, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_shadow_stage.sv
// pipe_shadow_stage: one shadow pipeline stage register
//   clk, rst : clock, synchronous active-high reset (clears the stage)
//   en       : advance; loads d when high, holds otherwise
//   bubble   : when loading, insert an empty stage instead of d
//   d, q     : stage info in / registered stage info out
module pipe_shadow_stage
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    stage_info_t q_d, q_q;

    // A bubble is cleared completely so stale operand fields cannot drive forwarding.
    always_comb begin
        q_d = q_q;
        if (en) q_d = bubble ? '0 : d;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stall/flush control and forwarding selects for a 5-stage MIPS pipe
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pipe_hazard_ctrl_if (ID decode info in; pc/IF-ID/ID-EX controls,
//              forwarding selects, stall flag and saturating stall/flush counters out)
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int RF_WT  = 1,
    parameter int CNT_W  = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    stage_info_t id_info, ex_q, mem_q, wb_q;
    logic act, raw, br, stl, jmp, idex_flush;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    always_comb begin
        id_info        = '0;
        id_info.valid  = bus.run;
        id_info.rs     = reg_t'(bus.id_rs[REG_AW-1:0]);
        id_info.rt     = reg_t'(bus.id_rt[REG_AW-1:0]);
        id_info.use_rs = bus.id_use_rs;
        id_info.use_rt = bus.id_use_rt;
        id_info.dst    = reg_t'(bus.id_dst[REG_AW-1:0]);
        id_info.regwr  = bus.id_regwr;
        id_info.load   = bus.id_load;
    end

    // With forwarding only a load in EX is too late; without it any in-flight producer
    // blocks ID, and WB only matters when the register file cannot write-then-read.
    always_comb begin
        act = bus.run && !rst;
        raw = (FWD_EN != 0) ? (ex_q.load && src_hit(ex_q, id_info))
                            : (src_hit(ex_q, id_info) || src_hit(mem_q, id_info) ||
                               (RF_WT == 0 && src_hit(wb_q, id_info)));
        br  = act && bus.ex_br_taken;
        stl = act && !bus.ex_br_taken && raw;
        jmp = act && !bus.ex_br_taken && !raw && bus.id_jump;
        idex_flush = br || stl;
    end

    assign bus.pc_en      = act && !stl;
    assign bus.ifid_en    = act && !stl;
    assign bus.ifid_flush = br || jmp;
    assign bus.idex_flush = idex_flush;
    assign bus.stall      = stl;
    assign bus.fwd_a      = (FWD_EN != 0 && !rst) ? fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.use_rs) : FWD_RF;
    assign bus.fwd_b      = (FWD_EN != 0 && !rst) ? fwd_sel(mem_q, wb_q, ex_q.rt, ex_q.use_rt) : FWD_RF;

    pipe_shadow_stage u_ex (
        .clk(clk), .rst(rst), .en(bus.run), .bubble(idex_flush), .d(id_info), .q(ex_q)
    );
    pipe_shadow_stage u_mem (
        .clk(clk), .rst(rst), .en(bus.run), .bubble(1'b0), .d(ex_q), .q(mem_q)
    );
    pipe_shadow_stage u_wb (
        .clk(clk), .rst(rst), .en(bus.run), .bubble(1'b0), .d(mem_q), .q(wb_q)
    );

    always_comb begin
        stall_cnt_d = (stl && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = ((br || jmp) && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for a forwarding instance and a stall-only 3-bit-counter instance
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) f_if ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  s_if ();

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .RF_WT(1), .CNT_W(32)) dut_f (.clk(clk), .rst(rst), .bus(f_if));
    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .RF_WT(1), .CNT_W(3))  dut_s (.clk(clk), .rst(rst), .bus(s_if));

    typedef struct packed {
        bit sel, rst, run;
        logic [4:0] rs, rt, dst;
        bit urs, urt, wr, ld, jmp, br;
    } row_t;

    typedef struct packed {
        logic [8:0]  o;
        logic [31:0] sc;
        logic [31:0] fc;
    } res_t;

    // {pc_en, ifid_en, ifid_flush, idex_flush, stall, fwd_a, fwd_b}
    localparam logic [8:0] O_OFF = 9'b000000000;
    localparam logic [8:0] O_RUN = 9'b110000000;
    localparam logic [8:0] O_STL = 9'b000110000;
    localparam logic [8:0] O_JMP = 9'b111000000;
    localparam logic [8:0] O_BR  = 9'b111100000;

    row_t stim_q[$];
    res_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic row_t ins(input bit sel, input int rs, input int rt, input bit urs, input bit urt,
                                 input int dst, input bit wr, input bit ld);
        row_t r;
        r = '0;
        r.sel = sel; r.run = 1'b1;
        r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt;
        r.dst = 5'(dst); r.wr = wr; r.ld = ld;
        return r;
    endfunction

    function automatic row_t nop(input bit sel);
        return ins(sel, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    function automatic res_t obs(input bit sel);
        if (sel)
            return res_t'({s_if.pc_en, s_if.ifid_en, s_if.ifid_flush, s_if.idex_flush, s_if.stall,
                           s_if.fwd_a, s_if.fwd_b, 32'(s_if.stall_cnt), 32'(s_if.flush_cnt)});
        return res_t'({f_if.pc_en, f_if.ifid_en, f_if.ifid_flush, f_if.idex_flush, f_if.stall,
                       f_if.fwd_a, f_if.fwd_b, f_if.stall_cnt, f_if.flush_cnt});
    endfunction

    task automatic sb_push(input row_t r, input logic [8:0] o, input int sc, input int fc);
        stim_q.push_back(r);
        exp_q.push_back(res_t'({o, 32'(sc), 32'(fc)}));
    endtask

    task automatic apply(input row_t r);
        rst = r.rst;
        f_if.run = r.run;          s_if.run = r.run;
        f_if.id_rs = r.rs;         s_if.id_rs = r.rs;
        f_if.id_rt = r.rt;         s_if.id_rt = r.rt;
        f_if.id_use_rs = r.urs;    s_if.id_use_rs = r.urs;
        f_if.id_use_rt = r.urt;    s_if.id_use_rt = r.urt;
        f_if.id_dst = r.dst;       s_if.id_dst = r.dst;
        f_if.id_regwr = r.wr;      s_if.id_regwr = r.wr;
        f_if.id_load = r.ld;       s_if.id_load = r.ld;
        f_if.id_jump = r.jmp;      s_if.id_jump = r.jmp;
        f_if.ex_br_taken = r.br;   s_if.ex_br_taken = r.br;
    endtask

    task automatic do_reset();
        row_t r;
        r = nop(1'b0);
        r.rst = 1'b1;
        apply(r);
        repeat (2) @(posedge clk);
        #1;
        apply(nop(1'b0));
    endtask

    task automatic test_reset();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        r = ins(0, 4, 4, 1, 1, 4, 1, 1); r.rst = 1; r.jmp = 1; r.br = 1;
        sb_push(r, O_OFF, 0, 0);
        r.sel = 1;
        sb_push(r, O_OFF, 0, 0);
        sb_push(nop(0), O_RUN, 0, 0);
        for (int i = 0; i < 5; i++) begin
            sb_push(ins(0, 1, 0, 1, 0, 4, 1, 1), O_RUN, i, i);
            sb_push(ins(0, 4, 0, 1, 0, 5, 1, 0), O_STL, i, i);
            r = nop(0); r.jmp = 1;
            sb_push(r, O_JMP, i + 1, i);
        end
        sb_push(ins(0, 1, 0, 1, 0, 4, 1, 1), O_RUN, 5, 5);
        r = ins(0, 4, 0, 1, 0, 5, 1, 0); r.rst = 1;
        sb_push(r, O_OFF, 5, 5);
        sb_push(ins(0, 4, 0, 1, 0, 5, 1, 0), O_RUN, 0, 0);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL reset.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL reset.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL reset.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forwarding();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        sb_push(ins(0, 1, 2, 1, 1, 3, 1, 0), O_RUN, 0, 0);
        sb_push(ins(0, 3, 6, 1, 1, 7, 1, 0), O_RUN, 0, 0);
        sb_push(nop(0), 9'b110001000, 0, 0);
        sb_push(ins(0, 1, 2, 1, 1, 3, 1, 0), O_RUN, 0, 0);
        sb_push(nop(0), O_RUN, 0, 0);
        sb_push(ins(0, 3, 8, 1, 1, 9, 1, 0), O_RUN, 0, 0);
        sb_push(nop(0), 9'b110000100, 0, 0);
        sb_push(ins(0, 1, 2, 1, 1, 0, 1, 0), O_RUN, 0, 0);
        sb_push(ins(0, 0, 0, 1, 1, 9, 1, 0), O_RUN, 0, 0);
        sb_push(nop(0), O_RUN, 0, 0);
        sb_push(ins(0, 1, 2, 1, 1, 5, 1, 0), O_RUN, 0, 0);
        sb_push(ins(0, 1, 2, 1, 1, 5, 1, 0), O_RUN, 0, 0);
        sb_push(ins(0, 9, 5, 1, 1, 10, 1, 0), O_RUN, 0, 0);
        sb_push(nop(0), 9'b110000010, 0, 0);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL fwd.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL fwd.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL fwd.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        sb_push(ins(0, 1, 0, 1, 0, 4, 1, 1), O_RUN, 0, 0);
        sb_push(ins(0, 4, 2, 1, 1, 5, 1, 0), O_STL, 0, 0);
        sb_push(ins(0, 4, 2, 1, 1, 5, 1, 0), O_RUN, 1, 0);
        sb_push(nop(0), 9'b110000100, 1, 0);
        sb_push(nop(0), O_RUN, 1, 0);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL load_use.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL load_use.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL load_use.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_only();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        sb_push(ins(1, 1, 2, 1, 1, 5, 1, 0), O_RUN, 0, 0);
        sb_push(ins(1, 5, 6, 1, 1, 7, 1, 0), O_STL, 0, 0);
        sb_push(ins(1, 5, 6, 1, 1, 7, 1, 0), O_STL, 1, 0);
        sb_push(ins(1, 5, 6, 1, 1, 7, 1, 0), O_RUN, 2, 0);
        sb_push(nop(1), O_RUN, 2, 0);
        sb_push(nop(1), O_RUN, 2, 0);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL stall_only.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL stall_only.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL stall_only.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        sb_push(ins(0, 1, 0, 1, 0, 4, 1, 1), O_RUN, 0, 0);
        r = ins(0, 4, 0, 1, 0, 5, 1, 0); r.jmp = 1; r.br = 1;
        sb_push(r, O_BR, 0, 0);
        sb_push(nop(0), O_RUN, 0, 1);
        sb_push(ins(0, 1, 0, 1, 0, 4, 1, 1), O_RUN, 0, 1);
        r = ins(0, 4, 0, 1, 0, 5, 1, 0); r.jmp = 1;
        sb_push(r, O_STL, 0, 1);
        sb_push(nop(0), O_RUN, 1, 1);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL priority.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL priority.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL priority.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_run_freeze();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        sb_push(ins(0, 1, 2, 1, 1, 3, 1, 0), O_RUN, 0, 0);
        sb_push(ins(0, 3, 0, 1, 0, 4, 1, 1), O_RUN, 0, 0);
        r = ins(0, 4, 0, 1, 0, 5, 1, 0); r.run = 0;
        repeat (3) sb_push(r, 9'b000001000, 0, 0);
        sb_push(ins(0, 4, 0, 1, 0, 5, 1, 0), 9'b000111000, 0, 0);
        sb_push(ins(0, 4, 0, 1, 0, 5, 1, 0), O_RUN, 1, 0);
        sb_push(nop(0), 9'b110000100, 1, 0);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL freeze.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL freeze.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL freeze.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        row_t r;
        res_t a, e;
        int c = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            r = nop(1); r.jmp = 1;
            sb_push(r, O_JMP, 0, (i > 7) ? 7 : i);
        end
        sb_push(nop(1), O_RUN, 0, 7);
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            apply(r);
            @(negedge clk);
            e = exp_q.pop_front();
            a = obs(r.sel);
            n_cmp += 3;
            if (a.o !== e.o) begin n_bad++; $display("FAIL saturate.outputs cyc %0d got %b want %b", c, a.o, e.o); end
            if (a.sc !== e.sc) begin n_bad++; $display("FAIL saturate.stall_cnt cyc %0d got %0d want %0d", c, a.sc, e.sc); end
            if (a.fc !== e.fc) begin n_bad++; $display("FAIL saturate.flush_cnt cyc %0d got %0d want %0d", c, a.fc, e.fc); end
            c++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_stall_only();
        test_priority();
        test_run_freeze();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined MIPS core (IF/ID/EX/MEM/WB).
- Sits beside the controller and datapath in the pipeline top level.
- Keeps shadow copies of per-stage destination info and produces stall/flush/enable and forwarding selects.
- Adds two modes: forwarding and stall-only. Adds saturating stall and flush performance counters.

Parameters:
REG_AW, 5, register-address width.
FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = resolve RAW hazards by stalling only.
RF_WT, 1, 1 = register file writes in the first half-cycle and reads in the second, so WB never conflicts with ID.
CNT_W, 32, performance counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
run  in  1  global advance enable; 0 freezes the pipeline
id_rs  in  REG_AW  rs field of the instruction in ID
id_rt  in  REG_AW  rt field of the instruction in ID
id_use_rs  in  1  instruction in ID reads rs
id_use_rt  in  1  instruction in ID reads rt
id_dst  in  REG_AW  destination register (after the RegDst mux)
id_regwr  in  1  instruction in ID writes the register file
id_load  in  1  instruction in ID is a load (MemtoReg)
id_jump  in  1  jump decoded in ID
ex_br_taken  in  1  branch resolved taken in EX
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID becomes a bubble
idex_flush  out  1  ID/EX becomes a bubble
fwd_a  out  2  ALU A source select for EX
fwd_b  out  2  ALU B source select for EX
stall  out  1  hazard stall active this cycle
stall_cnt  out  CNT_W  stall cycles counted
flush_cnt  out  CNT_W  flush events counted

Behaviour:
- Shadow stages ex, mem, wb. Each holds {valid, rs, rt, use_rs, use_rt, dst, regwr, load}. The shadow stages are registered; all outputs are combinational from the shadow state plus the ID inputs.
- ID is treated as valid whenever run=1.
- Register 0 never creates a hazard and is never forwarded.
- Hazard match(s, x): stage x is valid, x.regwr=1, x.dst=s, s≠0, and the ID source s is in use.
- Stall condition, FWD_EN=1: ex.load and match(id_rs or id_rt, ex).
- Stall condition, FWD_EN=0: match against ex or mem. When RF_WT=0, also match against wb.
- Priority: ex_br_taken > stall > id_jump.
  - Branch: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1, stall=0. flush_cnt +1.
  - Stall: pc_en=0, ifid_en=0, idex_flush=1. stall_cnt +1.
  - Jump (not stalled): ifid_flush=1, pc_en=1. flush_cnt +1.
  - Otherwise: pc_en=1, ifid_en=1, all flushes 0.
- Jump while stalled: ignored this cycle. It is re-presented by the held IF/ID register.
- Advance when run=1:
  - wb <= mem; mem <= ex.
  - ex <= ID info, except ex.valid <= 0 when idex_flush is asserted.
- Forwarding (FWD_EN=1), computed from EX operands:
  - fwd_a=2'b10 when mem.valid, mem.regwr, mem.dst=ex.rs≠0 and ex.use_rs.
  - Otherwise fwd_a=2'b01 when the same conditions hold against wb.
  - Otherwise fwd_a=2'b00.
  - fwd_b is identical using ex.rt. MEM takes priority over WB.
- FWD_EN=0: fwd_a=fwd_b=2'b00 always.
- run=0:
  - Shadow state and counters hold.
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=0, stall=0.
  - fwd_* still reflects the held state.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Reset (sync, overrides run, valid mid-operation):
  - All shadow valids=0, counters=0.
  - While rst=1: pc_en=0, ifid_en=0, flushes=0, stall=0, fwd=00.
  - In the first cycle after reset: no hazards, pc_en=1.

Decomposition:
- Package pipe_pkg: FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01, and the stage_info_t struct.
- Sub-module pipe_shadow_stage: one stage_info_t register with enable and bubble, instantiated three times.

Test Plan:
- Reset asserted mid-stall with counters at 5 → next cycle stall_cnt=0, flush_cnt=0, stall=0, pc_en=1.
- FWD_EN=1: add $3 in ID, then sub using $3 next → in sub's EX cycle fwd_a=10. With one nop between them → fwd_a=01. Using $0 → fwd_a=00.
- FWD_EN=1: lw $4, then add using $4 → exactly 1 stall cycle (pc_en=0, idex_flush=1). Then fwd=01, stall_cnt=1.
- FWD_EN=0, RF_WT=1: add $5, then or using $5 → 2 stall cycles, stall_cnt=2, fwd always 00.
- ex_br_taken in the same cycle as a load-use stall and an id_jump → both flushes asserted, pc_en=1, stall=0, flush_cnt +1, stall_cnt unchanged.
- run=0 for 3 cycles during a hazard → outputs 0, shadow/counters unchanged; on resume the stall completes as normal. flush_cnt preset near 2^CNT_W−1 saturates.
